// File: rtl/noc_pkg.sv
// Shared definitions for the local network interface: packet field layout,
// packet type codes, TX queue entry format and saturating counter helpers.
package noc_pkg;

  localparam int ADDR_W    = 4;
  localparam int TS_W      = 8;
  localparam int PAYLOAD_W = 22;
  localparam int TYPE_W    = 2;

  // 40-bit packet: [39:36]src [35:32]dst [31:24]timestamp [23:2]data [1:0]type
  localparam int SRC_MSB  = 39;
  localparam int SRC_LSB  = 36;
  localparam int DST_MSB  = 35;
  localparam int DST_LSB  = 32;
  localparam int TS_MSB   = 31;
  localparam int TS_LSB   = 24;
  localparam int DATA_MSB = 23;
  localparam int DATA_LSB = 2;
  localparam int TYPE_MSB = 1;
  localparam int TYPE_LSB = 0;

  localparam logic [TYPE_W-1:0] TYPE_DATA = 2'b00;
  localparam logic [TYPE_W-1:0] TYPE_REQ  = 2'b01;
  localparam logic [TYPE_W-1:0] TYPE_RSP  = 2'b10;
  localparam logic [TYPE_W-1:0] TYPE_RSV  = 2'b11;

  // What waits in the TX queue / RSP slot; src and timestamp are added at issue.
  typedef struct packed {
    logic [ADDR_W-1:0]    dst;
    logic [PAYLOAD_W-1:0] data;
    logic [TYPE_W-1:0]    typ;
  } tx_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/noc_ni_txq.sv
// Synchronous FIFO holding core TX requests until the router can take them.
// A push on a full queue is accepted only when a pop frees a slot that cycle.
module noc_ni_txq #(
  parameter int W     = 28,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Occupancy flags, guarded push/pop and next pointer/count values.
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
    rdata    = mem_q[rd_ptr_q];
    count    = count_q;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/noc_local_ni.sv
// Local-port network interface. TX: queue core requests and inject them into
// the router with an RSP slot taking priority. RX: decode ejected packets,
// report fields and latency, and turn accepted REQs into RSPs.
// Handshake: a request transfers on a cycle where req_valid && req_ready;
// the router side has no ready, instead router_full==1 blocks issue.
module noc_local_ni
  import noc_pkg::*;
#(
  parameter int          DATASIZE  = 40,
  parameter logic [3:0]  NODE_ID   = 4'h0,
  parameter int          TXQ_DEPTH = 4,
  parameter int          TXQ_AW    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_dst,
  input  logic [21:0]         req_data,
  input  logic [1:0]          req_type,
  output logic [DATASIZE-1:0] ni_data_out,
  output logic                ni_valid_out,
  input  logic                router_full,
  input  logic [DATASIZE-1:0] ni_data_in,
  input  logic                ni_valid_in,
  output logic                rx_valid,
  output logic [3:0]          rx_src,
  output logic [21:0]         rx_data,
  output logic [1:0]          rx_type,
  output logic [7:0]          rx_latency,
  output logic                misroute,
  output logic [15:0]         tx_count,
  output logic [15:0]         rx_count,
  output logic [7:0]          rsp_drop
);

  localparam logic [TXQ_AW:0] TXQ_FULL_CNT = (TXQ_AW+1)'(TXQ_DEPTH);

  logic [TS_W-1:0]     ts_now_q, ts_now_d;
  tx_entry_t           txq_wdata, txq_rdata, issue_entry;
  tx_entry_t           rsp_slot_q, rsp_slot_d;
  logic                rsp_full_q, rsp_full_d;
  logic                txq_push, txq_pop, txq_full, txq_empty;
  logic [TXQ_AW:0]     txq_count;
  logic                issue;
  logic [DATASIZE-1:0] ni_data_out_q, ni_data_out_d;
  logic                ni_valid_out_q, ni_valid_out_d;
  logic                rx_valid_q, rx_valid_d, misroute_q, misroute_d;
  logic [3:0]          rx_src_q, rx_src_d;
  logic [21:0]         rx_data_q, rx_data_d;
  logic [1:0]          rx_type_q, rx_type_d;
  logic [7:0]          rx_latency_q, rx_latency_d;
  logic [15:0]         tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [7:0]          rsp_drop_q, rsp_drop_d;
  logic                accept;

  noc_ni_txq #(.W($bits(tx_entry_t)), .DEPTH(TXQ_DEPTH), .AW(TXQ_AW)) u_txq (
    .clk(clk), .rst_n(rst_n), .push(txq_push), .wdata(txq_wdata),
    .pop(txq_pop), .rdata(txq_rdata), .full(txq_full), .empty(txq_empty),
    .count(txq_count)
  );

  // TX side: enqueue, arbitrate RSP slot over queue head, build issued packet.
  always_comb begin
    ts_now_d       = ts_now_q + 8'd1;
    req_ready      = (txq_count != TXQ_FULL_CNT);
    txq_push       = req_valid && !txq_full;
    txq_wdata.dst  = req_dst;
    txq_wdata.data = req_data;
    txq_wdata.typ  = (req_type == TYPE_RSV) ? TYPE_DATA : req_type;
    issue          = !router_full && (rsp_full_q || !txq_empty);
    txq_pop        = issue && !rsp_full_q;
    issue_entry    = rsp_full_q ? rsp_slot_q : txq_rdata;
    ni_valid_out_d = issue;
    ni_data_out_d  = issue ? {NODE_ID, issue_entry.dst, ts_now_q,
                              issue_entry.data, issue_entry.typ}
                           : ni_data_out_q;
    tx_count_d     = issue ? sat_inc16(tx_count_q) : tx_count_q;
  end

  // RX side: decode, latency, counters and the auto-responder slot.
  always_comb begin
    accept       = ni_valid_in && (ni_data_in[DST_MSB:DST_LSB] == NODE_ID);
    rx_valid_d   = accept;
    misroute_d   = ni_valid_in && !accept;
    rx_src_d     = accept ? ni_data_in[SRC_MSB:SRC_LSB]   : rx_src_q;
    rx_data_d    = accept ? ni_data_in[DATA_MSB:DATA_LSB] : rx_data_q;
    rx_type_d    = accept ? ni_data_in[TYPE_MSB:TYPE_LSB] : rx_type_q;
    rx_latency_d = accept ? ts_now_q - ni_data_in[TS_MSB:TS_LSB] : rx_latency_q;
    rx_count_d   = accept ? sat_inc16(rx_count_q) : rx_count_q;
    // The slot counts as free if it is empty or being issued this cycle.
    rsp_full_d   = rsp_full_q && !issue;
    rsp_slot_d   = rsp_slot_q;
    rsp_drop_d   = rsp_drop_q;
    if (accept && (ni_data_in[TYPE_MSB:TYPE_LSB] == TYPE_REQ)) begin
      if (!rsp_full_d) begin
        rsp_full_d      = 1'b1;
        rsp_slot_d.dst  = ni_data_in[SRC_MSB:SRC_LSB];
        rsp_slot_d.data = ni_data_in[DATA_MSB:DATA_LSB];
        rsp_slot_d.typ  = TYPE_RSP;
      end else begin
        rsp_drop_d = sat_inc8(rsp_drop_q);
      end
    end
  end

  // State registers; reset clears everything including in-flight RX results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_now_q <= '0; rsp_slot_q <= '0; rsp_full_q <= 1'b0;
      ni_data_out_q <= '0; ni_valid_out_q <= 1'b0;
      rx_valid_q <= 1'b0; misroute_q <= 1'b0; rx_src_q <= '0;
      rx_data_q <= '0; rx_type_q <= '0; rx_latency_q <= '0;
      tx_count_q <= '0; rx_count_q <= '0; rsp_drop_q <= '0;
    end else begin
      ts_now_q <= ts_now_d; rsp_slot_q <= rsp_slot_d; rsp_full_q <= rsp_full_d;
      ni_data_out_q <= ni_data_out_d; ni_valid_out_q <= ni_valid_out_d;
      rx_valid_q <= rx_valid_d; misroute_q <= misroute_d; rx_src_q <= rx_src_d;
      rx_data_q <= rx_data_d; rx_type_q <= rx_type_d; rx_latency_q <= rx_latency_d;
      tx_count_q <= tx_count_d; rx_count_q <= rx_count_d; rsp_drop_q <= rsp_drop_d;
    end
  end

  assign ni_data_out  = ni_data_out_q;
  assign ni_valid_out = ni_valid_out_q;
  assign rx_valid     = rx_valid_q;
  assign misroute     = misroute_q;
  assign rx_src       = rx_src_q;
  assign rx_data      = rx_data_q;
  assign rx_type      = rx_type_q;
  assign rx_latency   = rx_latency_q;
  assign tx_count     = tx_count_q;
  assign rx_count     = rx_count_q;
  assign rsp_drop     = rsp_drop_q;

endmodule
